// File: rtl/wb_queue.sv
// wb_queue: circular write-back queue feeding a single register-file write port,
// with youngest-entry forwarding lookups for two decode-stage source registers.
`default_nettype none

module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [31:0]              in_wd,
  input  logic                     gpr_stall,
  output logic                     gpr_we,
  output logic [4:0]               gpr_rd,
  output logic [31:0]              gpr_wd,
  input  logic [4:0]               q_rs,
  input  logic [4:0]               q_rt,
  output logic                     hit_a,
  output logic                     hit_b,
  output logic [31:0]              fwd_a,
  output logic [31:0]              fwd_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    rd_mem [DEPTH];
  logic [31:0]   wd_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push;
  logic          pop;

  assign in_ready = (count < CW'(DEPTH));
  // Writes to r0 complete the handshake but are never stored.
  assign push     = in_valid && in_ready && (in_rd != 5'd0);
  assign gpr_we   = (count != '0) && !gpr_stall;
  assign pop      = gpr_we;
  assign gpr_rd   = gpr_we ? rd_mem[head] : 5'd0;
  assign gpr_wd   = gpr_we ? wd_mem[head] : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Entry payload needs no reset; validity comes from head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail] <= in_rd;
      wd_mem[tail] <= in_wd;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = 32'd0;
    fwd_b = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if ((q_rs != 5'd0) && (rd_mem[head + AW'(k)] == q_rs)) begin
          hit_a = 1'b1;
          fwd_a = wd_mem[head + AW'(k)];
        end
        if ((q_rt != 5'd0) && (rd_mem[head + AW'(k)] == q_rt)) begin
          hit_b = 1'b1;
          fwd_b = wd_mem[head + AW'(k)];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_queue.sv
// tb_wb_queue: scenario tasks plus a scoreboard of expected register writes.
`default_nettype none

module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_wd;
  logic        gpr_stall;
  logic        gpr_we;
  logic [4:0]  gpr_rd;
  logic [31:0] gpr_wd;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        hit_a;
  logic        hit_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [36:0] sb [$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wd(in_wd),
    .gpr_stall(gpr_stall), .gpr_we(gpr_we), .gpr_rd(gpr_rd), .gpr_wd(gpr_wd),
    .q_rs(q_rs), .q_rt(q_rt), .hit_a(hit_a), .hit_b(hit_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .count(count)
  );

  always #5 clk = ~clk;

  // One clock: check outputs at the falling edge against the scoreboard,
  // record what the coming rising edge will accept, then return just after it.
  task automatic tick();
    logic        m_ready;
    logic        m_we;
    logic [36:0] exp_e;
    @(negedge clk);
    m_ready = (sb.size() < DEPTH);
    m_we    = (sb.size() != 0) && !gpr_stall;
    checks++;
    if (in_ready !== m_ready) begin
      fails++; $display("FAIL mon_in_ready: got %b expected %b", in_ready, m_ready);
    end else passes++;
    checks++;
    if (count !== 3'(sb.size())) begin
      fails++; $display("FAIL mon_count: got %0d expected %0d", count, sb.size());
    end else passes++;
    checks++;
    if (gpr_we !== m_we) begin
      fails++; $display("FAIL mon_gpr_we: got %b expected %b", gpr_we, m_we);
    end else passes++;
    if (m_we) exp_e = sb.pop_front();
    else      exp_e = '0;
    checks++;
    if ({gpr_rd, gpr_wd} !== exp_e) begin
      fails++;
      $display("FAIL mon_gpr_data: got rd=%0d wd=%h expected rd=%0d wd=%h",
               gpr_rd, gpr_wd, exp_e[36:32], exp_e[31:0]);
    end else passes++;
    if (in_valid && m_ready && (in_rd != 5'd0)) sb.push_back({in_rd, in_wd});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
    end else passes++;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] wd);
    in_valid = 1'b1; in_rd = rd; in_wd = wd;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_wd = '0;
    gpr_stall = 1'b0; q_rs = 5'd5; q_rt = 5'd9;
    #1;
    checks++;
    if ({in_ready, gpr_we, gpr_rd, gpr_wd, hit_a, hit_b, fwd_a, fwd_b, count} !==
        {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0}) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b we=%b rd=%0d wd=%h ha=%b hb=%b fa=%h fb=%h cnt=%0d expected 1 0 0 0 0 0 0 0 0",
               in_ready, gpr_we, gpr_rd, gpr_wd, hit_a, hit_b, fwd_a, fwd_b, count);
    end else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    gpr_stall = 1'b0;
    offer(5'd5, 32'h1234);
    checks++;
    if ({gpr_we, gpr_rd, gpr_wd} !== {1'b1, 5'd5, 32'h1234}) begin
      fails++;
      $display("FAIL single_out: got we=%b rd=%0d wd=%h expected 1 5 1234", gpr_we, gpr_rd, gpr_wd);
    end else passes++;
    tick();
    checks++;
    if ({gpr_we, count} !== {1'b0, 3'd0}) begin
      fails++; $display("FAIL single_after: got we=%b cnt=%0d expected 0 0", gpr_we, count);
    end else passes++;
  endtask

  task automatic test_fill_stall();
    gpr_stall = 1'b1;
    for (int r = 1; r <= 4; r++) offer(5'(r), 32'h100 + 32'(r));
    checks++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      fails++; $display("FAIL fill_full: got cnt=%0d rdy=%b expected 4 0", count, in_ready);
    end else passes++;
    in_valid = 1'b1; in_rd = 5'd6; in_wd = 32'h606;
    tick(); tick();
    checks++;
    if (count !== 3'd4) begin
      fails++; $display("FAIL fill_ignored: got cnt=%0d expected 4", count);
    end else passes++;
    gpr_stall = 1'b0;
    tick();
    checks++;
    if (gpr_rd !== 5'd2) begin
      fails++; $display("FAIL fill_order: got rd=%0d expected 2", gpr_rd);
    end else passes++;
    tick();
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_forwarding();
    gpr_stall = 1'b1;
    offer(5'd7, 32'hA);
    offer(5'd7, 32'hB);
    q_rs = 5'd7; q_rt = 5'd8;
    #1;
    checks++;
    if ({hit_a, fwd_a, hit_b, fwd_b} !== {1'b1, 32'hB, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL fwd_youngest: got ha=%b fa=%h hb=%b fb=%h expected 1 b 0 0", hit_a, fwd_a, hit_b, fwd_b);
    end else passes++;
    in_valid = 1'b1; in_rd = 5'd8; in_wd = 32'hC;
    #1;
    checks++;
    if (hit_b !== 1'b0) begin
      fails++; $display("FAIL fwd_excl_offer: got hb=%b expected 0", hit_b);
    end else passes++;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({hit_b, fwd_b} !== {1'b1, 32'hC}) begin
      fails++; $display("FAIL fwd_b_hit: got hb=%b fb=%h expected 1 c", hit_b, fwd_b);
    end else passes++;
    q_rs = 5'd0;
    #1;
    checks++;
    if ({hit_a, fwd_a} !== {1'b0, 32'h0}) begin
      fails++; $display("FAIL fwd_r0: got ha=%b fa=%h expected 0 0", hit_a, fwd_a);
    end else passes++;
    gpr_stall = 1'b0; q_rs = 5'd7;
    #1;
    checks++;
    if ({gpr_we, hit_a, fwd_a} !== {1'b1, 1'b1, 32'hB}) begin
      fails++; $display("FAIL fwd_popping: got we=%b ha=%b fa=%h expected 1 1 b", gpr_we, hit_a, fwd_a);
    end else passes++;
    drain();
    checks++;
    if ({hit_a, hit_b} !== 2'b00) begin
      fails++; $display("FAIL fwd_empty: got ha=%b hb=%b expected 0 0", hit_a, hit_b);
    end else passes++;
  endtask

  task automatic test_zero_reg();
    gpr_stall = 1'b0;
    in_valid = 1'b1; in_rd = 5'd0; in_wd = 32'hFFFF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL zero_ready: got %b expected 1", in_ready);
    end else passes++;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({count, gpr_we} !== {3'd0, 1'b0}) begin
      fails++; $display("FAIL zero_discard: got cnt=%0d we=%b expected 0 0", count, gpr_we);
    end else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    gpr_stall = 1'b1;
    offer(5'd10, 32'hAAAA0010);
    offer(5'd11, 32'hAAAA0011);
    gpr_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rd = 5'(12 + i); in_wd = $urandom;
      tick();
      checks++;
      if (count !== 3'd2) begin
        fails++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count);
      end else passes++;
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    gpr_stall = 1'b1;
    offer(5'd3, 32'h33);
    offer(5'd4, 32'h44);
    offer(5'd5, 32'h55);
    checks++;
    if (count !== 3'd3) begin
      fails++; $display("FAIL rstmid_pre: got cnt=%0d expected 3", count);
    end else passes++;
    q_rs = 5'd4;
    #2 gpr_stall = 1'b0;
    #1 rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({count, gpr_we, hit_a} !== {3'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL rstmid_clear: got cnt=%0d we=%b ha=%b expected 0 0 0", count, gpr_we, hit_a);
    end else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_forwarding();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
